// File: rtl/neuron_train_ctrl_pkg.sv
// Shared types for the perceptron training controller: state encoding,
// default sizing constants and the Moore output decode.
package neuron_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_CLR   = 4'd1,
        S_LOADN = 4'd2,
        S_EPOCH = 4'd3,
        S_CHECK = 4'd4,
        S_FETCH = 4'd5,
        S_EVAL  = 4'd6,
        S_NEXT  = 4'd7,
        S_DONE  = 4'd8
    } state_e;

    localparam int DEF_MAX_EPOCHS  = 64;
    localparam int DEF_EPOCH_W     = 8;
    localparam int DEF_ACK_TIMEOUT = 255;

    // Outputs that depend on state alone; registered alongside the state.
    typedef struct packed {
        logic busy;
        logic done;
        logic sample_req;
        logic reset;
        logic n_reset;
        logic ld_n;
        logic ld_flag;
        logic flag_reset;
        logic counter_en;
        logic counter_reset;
    } ctrl_t;

    function automatic ctrl_t moore_decode(state_e s);
        ctrl_t c;
        c      = '0;
        c.busy = (s != S_IDLE);
        case (s)
            S_CLR: begin
                c.reset   = 1'b1;
                c.n_reset = 1'b1;
            end
            S_LOADN: c.ld_n = 1'b1;
            S_EPOCH: begin
                c.counter_reset = 1'b1;
                c.flag_reset    = 1'b1;
            end
            S_FETCH: c.sample_req = 1'b1;
            S_EVAL:  c.ld_flag    = 1'b1;
            S_NEXT:  c.counter_en = 1'b1;
            S_DONE:  c.done       = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/neuron_train_ctrl_if.sv
// Controller <-> neuron datapath / sample source bundle.
// master = controller side, slave = datapath + sample source side.
interface neuron_train_ctrl_if;
    logic sampleReq;
    logic sampleAck;
    logic yEqualt;
    logic flagEOF;
    logic reset;
    logic nReset;
    logic ldRegN;
    logic ldRegx1;
    logic ldRegx2;
    logic ldRegT;
    logic ldRegW1;
    logic ldRegW2;
    logic ldRegB;
    logic ldRegFlag;
    logic flagReset;
    logic counterEn;
    logic counterReset;

    modport master (
        output sampleReq, reset, nReset, ldRegN, ldRegx1, ldRegx2, ldRegT,
               ldRegW1, ldRegW2, ldRegB, ldRegFlag, flagReset, counterEn,
               counterReset,
        input  sampleAck, yEqualt, flagEOF
    );

    modport slave (
        input  sampleReq, reset, nReset, ldRegN, ldRegx1, ldRegx2, ldRegT,
               ldRegW1, ldRegW2, ldRegB, ldRegFlag, flagReset, counterEn,
               counterReset,
        output sampleAck, yEqualt, flagEOF
    );
endinterface

// File: rtl/neuron_train_ctrl_ack_watchdog.sv
// Sample-ack watchdog: cleared on load, counts cycles waiting for ack,
// flags expiry on the cycle the count reaches LIMIT.
module neuron_ack_watchdog #(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic count_i,
    output logic expire_o
);
    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [W-1:0] count_q;

    // Expiry is flagged on the LIMIT-th waiting cycle so the FSM leaves
    // FETCH exactly LIMIT cycles after entering it.
    assign expire_o = count_i && (count_q == W'(LIMIT - 1));

    // Wait-cycle counter; wrap after expiry is harmless since FETCH is left.
    always_ff @(posedge clk) begin
        if (rst || load_i) begin
            count_q <= '0;
        end else if (count_i) begin
            count_q <= count_q + 1'b1;
        end
    end
endmodule

// File: rtl/neuron_train_ctrl.sv
// Perceptron training sequencer. Optional ack watchdog enabled by
// defining NEURON_CTRL_TIMEOUT_EN (adds ACK_TIMEOUT and timeoutErr).
module neuron_train_ctrl
    import neuron_ctrl_pkg::*;
#(
    parameter int MAX_EPOCHS  = DEF_MAX_EPOCHS,
    parameter int EPOCH_W     = DEF_EPOCH_W
`ifdef NEURON_CTRL_TIMEOUT_EN
    ,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic [EPOCH_W-1:0] epochCount,
`ifdef NEURON_CTRL_TIMEOUT_EN
    output logic               timeoutErr,
`endif
    neuron_train_ctrl_if.master dp
);
    state_e             state_q, state_d;
    ctrl_t              ctrl_q;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               conv_q, conv_d;
    logic               err_q, err_d;

`ifdef NEURON_CTRL_TIMEOUT_EN
    logic timeout_q, timeout_d;
    logic wd_expire;

    neuron_ack_watchdog #(.LIMIT(ACK_TIMEOUT)) u_wd (
        .clk      (clk),
        .rst      (rst),
        .load_i   ((state_d == S_FETCH) && (state_q != S_FETCH)),
        .count_i  ((state_q == S_FETCH) && !dp.sampleAck),
        .expire_o (wd_expire)
    );

    assign timeoutErr = timeout_q;
`endif

    // Next-state and run-status update.
    always_comb begin
        state_d = state_q;
        epoch_d = epoch_q;
        conv_d  = conv_q;
        err_d   = err_q;
`ifdef NEURON_CTRL_TIMEOUT_EN
        timeout_d = timeout_q;
`endif
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLR;
            S_CLR: begin
                epoch_d = '0;
                conv_d  = 1'b0;
`ifdef NEURON_CTRL_TIMEOUT_EN
                timeout_d = 1'b0;
`endif
                state_d = S_LOADN;
            end
            S_LOADN: state_d = S_EPOCH;
            S_EPOCH: begin
                err_d   = 1'b0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!dp.flagEOF) begin
                    state_d = S_FETCH;
                end else if (!err_q) begin
                    conv_d  = 1'b1;
                    state_d = S_DONE;
                end else if (epoch_q == EPOCH_W'(MAX_EPOCHS - 1)) begin
                    epoch_d = epoch_q + 1'b1;
                    state_d = S_DONE;
                end else begin
                    epoch_d = epoch_q + 1'b1;
                    state_d = S_EPOCH;
                end
            end
            S_FETCH: begin
                if (dp.sampleAck) begin
                    state_d = S_EVAL;
                end
`ifdef NEURON_CTRL_TIMEOUT_EN
                else if (wd_expire) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end
`endif
            end
            S_EVAL: begin
                if (!dp.yEqualt) err_d = 1'b1;
                state_d = S_NEXT;
            end
            S_NEXT:  state_d = S_CHECK;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State, registered Moore outputs and run status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
            epoch_q <= '0;
            conv_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef NEURON_CTRL_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ctrl_q  <= moore_decode(state_d);
            epoch_q <= epoch_d;
            conv_q  <= conv_d;
            err_q   <= err_d;
`ifdef NEURON_CTRL_TIMEOUT_EN
            timeout_q <= timeout_d;
`endif
        end
    end

    assign busy       = ctrl_q.busy;
    assign done       = ctrl_q.done;
    assign converged  = conv_q;
    assign epochCount = epoch_q;

    assign dp.sampleReq    = ctrl_q.sample_req;
    assign dp.reset        = ctrl_q.reset;
    assign dp.nReset       = ctrl_q.n_reset;
    assign dp.ldRegN       = ctrl_q.ld_n;
    assign dp.ldRegFlag    = ctrl_q.ld_flag;
    assign dp.flagReset    = ctrl_q.flag_reset;
    assign dp.counterEn    = ctrl_q.counter_en;
    assign dp.counterReset = ctrl_q.counter_reset;

    // Sample capture happens in the ack cycle itself; weight update strobes
    // follow the live compare result during EVAL.
    assign dp.ldRegx1 = (state_q == S_FETCH) && dp.sampleAck;
    assign dp.ldRegx2 = (state_q == S_FETCH) && dp.sampleAck;
    assign dp.ldRegT  = (state_q == S_FETCH) && dp.sampleAck;
    assign dp.ldRegW1 = (state_q == S_EVAL) && !dp.yEqualt;
    assign dp.ldRegW2 = (state_q == S_EVAL) && !dp.yEqualt;
    assign dp.ldRegB  = (state_q == S_EVAL) && !dp.yEqualt;
endmodule

// File: tb/tb_neuron_train_ctrl.sv
// Testbench for neuron_train_ctrl with a small datapath model
// (n register, sample counter, EOF compare) and a scripted ack source.
module tb_neuron_train_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, converged;
    logic [7:0] epochCount;
`ifdef NEURON_CTRL_TIMEOUT_EN
    logic       timeoutErr;
`endif

    neuron_train_ctrl_if dp ();

    neuron_train_ctrl #(
        .MAX_EPOCHS (3),
        .EPOCH_W    (8)
`ifdef NEURON_CTRL_TIMEOUT_EN
        ,
        .ACK_TIMEOUT(4)
`endif
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .converged  (converged),
        .epochCount (epochCount),
`ifdef NEURON_CTRL_TIMEOUT_EN
        .timeoutErr (timeoutErr),
`endif
        .dp         (dp)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    // datapath model
    int n_input   = 0;
    int n_m       = 0;
    int cnt_m     = 0;
    int ep_m      = 0;
    int ymode     = 1;     // 0: always mismatch, 1: always match, 2: mismatch in first epoch only
    int ack_delay = 0;
    int wcnt      = 0;

    always @(posedge clk) begin
        if (dp.nReset) n_m <= 0;
        else if (dp.ldRegN) n_m <= n_input;
        if (dp.counterReset) cnt_m <= 0;
        else if (dp.counterEn) cnt_m <= cnt_m + 1;
        if (dp.reset) ep_m <= 0;
        else if (dp.counterReset) ep_m <= ep_m + 1;
    end

    assign dp.flagEOF = (cnt_m == n_m);
    assign dp.yEqualt = (ymode == 1) ? 1'b1 : (ymode == 0) ? 1'b0 : (ep_m >= 2);

    // ack source: answers after ack_delay request cycles
    initial begin
        dp.sampleAck = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (dp.sampleReq) begin
                if (wcnt >= ack_delay) dp.sampleAck = 1'b1;
                else begin
                    dp.sampleAck = 1'b0;
                    wcnt++;
                end
            end else begin
                dp.sampleAck = 1'b0;
                wcnt = 0;
            end
        end
    end

    // strobe counters
    logic cnt_en = 1'b0;
    int x1_c, x2_c, t_c, w1_c, w2_c, b_c, req_c;
    always @(negedge clk) begin
        if (cnt_en) begin
            x1_c  += int'(dp.ldRegx1);
            x2_c  += int'(dp.ldRegx2);
            t_c   += int'(dp.ldRegT);
            w1_c  += int'(dp.ldRegW1);
            w2_c  += int'(dp.ldRegW2);
            b_c   += int'(dp.ldRegB);
            req_c += int'(dp.sampleReq);
        end
    end

    function automatic logic any_ctrl();
        return dp.reset | dp.nReset | dp.ldRegN | dp.ldRegx1 | dp.ldRegx2 |
               dp.ldRegT | dp.ldRegW1 | dp.ldRegW2 | dp.ldRegB | dp.ldRegFlag |
               dp.flagReset | dp.counterEn | dp.counterReset | dp.sampleReq;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    typedef struct {
        string nm;
        int    n;
        int    ym;
        int    d;
        int    exp_cyc;
        int    exp_conv;
        int    exp_ep;
        int    exp_x;
        int    exp_w;
        int    exp_req;
    } vec_t;

    // Start a run, wait for done, and compare the run summary.
    task automatic run_vec(input vec_t v);
        int cyc;
        n_input   = v.n;
        ymode     = v.ym;
        ack_delay = v.d;
        x1_c = 0; x2_c = 0; t_c = 0; w1_c = 0; w2_c = 0; b_c = 0; req_c = 0;
        @(negedge clk);
        cnt_en = 1'b1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({v.nm, ".busy_after_start"}, busy, 1);
        cyc = 1;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            // start while busy must not disturb the run
            start = (cyc == 10 && v.exp_cyc > 12);
        end
        start = 1'b0;
        chk({v.nm, ".done_cycle"}, cyc, v.exp_cyc);
        chk({v.nm, ".busy_in_done"}, busy, 1);
        chk({v.nm, ".converged"}, converged, v.exp_conv);
        chk({v.nm, ".epochCount"}, epochCount, v.exp_ep);
        @(negedge clk);
        cnt_en = 1'b0;
        chk({v.nm, ".done_pulse_len"}, done, 0);
        chk({v.nm, ".busy_after_done"}, busy, 0);
        chk({v.nm, ".ldRegx1_pulses"}, x1_c, v.exp_x);
        chk({v.nm, ".ldRegx2_T_pulses"}, x2_c + t_c, 2 * v.exp_x);
        chk({v.nm, ".ldRegW1_pulses"}, w1_c, v.exp_w);
        chk({v.nm, ".ldRegW2_B_pulses"}, w2_c + b_c, 2 * v.exp_w);
        chk({v.nm, ".sampleReq_cycles"}, req_c, v.exp_req);
    endtask

    vec_t vt[6];

    initial begin
        int k;
        // done cycle = 5 + E*n*(4+d) + 2*(E-1) for E epochs run
        vt[0] = '{"n0",          0, 1, 0,  5, 1, 0, 0, 0, 0};
        vt[1] = '{"n2_clean",    2, 1, 0, 13, 1, 0, 2, 0, 2};
        vt[2] = '{"n2_fix",      2, 2, 0, 23, 1, 1, 4, 2, 4};
        vt[3] = '{"n2_maxep",    2, 0, 0, 33, 0, 3, 6, 6, 6};
        vt[4] = '{"n3_ackwait",  3, 1, 2, 23, 1, 0, 3, 0, 9};
        vt[5] = '{"n1_maxep",    1, 0, 0, 21, 0, 3, 3, 3, 3};

        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.ctrl", any_ctrl(), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle.epochCount", epochCount, 0);
        chk("idle.converged", converged, 0);

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // reset in the middle of FETCH during the second epoch
        n_input = 1; ymode = 2; ack_delay = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (epochCount != 8'd1 && k < 100) begin @(negedge clk); k++; end
        ack_delay = 1000;
        while (!dp.sampleReq && k < 100) begin @(negedge clk); k++; end
        chk("midrst.reached_fetch", dp.sampleReq, 1);
        chk("midrst.epoch_before", epochCount, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.busy", busy, 0);
        chk("midrst.sampleReq", dp.sampleReq, 0);
        chk("midrst.epochCount", epochCount, 0);
        chk("midrst.ctrl", any_ctrl(), 0);
        chk("midrst.done", done, 0);
        rst = 1'b0;
        run_vec(vt[1]);

`ifdef NEURON_CTRL_TIMEOUT_EN
        begin
            vec_t tv;
            tv = '{"timeout", 2, 1, 1000, 9, 0, 0, 0, 0, 4};
            run_vec(tv);
            chk("timeout.timeoutErr", timeoutErr, 1);
            run_vec(vt[0]);
            chk("timeout.cleared", timeoutErr, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/neuron_train_ctrl.md
Name: neuron_train_ctrl

Overview:
- FSM controller that sequences perceptron training on the neuron datapath (x1/x2/t regs, w1/w2/b regs, sample counter, n reg).
- Fetches samples from an external sample source via req/ack, evaluates each one, and updates weights on a mismatch.
- Runs whole epochs until an epoch completes with zero errors or MAX_EPOCHS is reached.
- Sits between the top-level host (start/done) and the datapath.

Parameters:
- MAX_EPOCHS, 64: epoch limit before giving up.
- EPOCH_W, 8: width of epochCount; must satisfy 2^EPOCH_W > MAX_EPOCHS.
- ACK_TIMEOUT, 255: watchdog limit in cycles; used only with NEURON_CTRL_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a training run; sampled in IDLE only.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a run.
- converged  out  1  last run ended with an error-free epoch; held until the next start.
- epochCount  out  EPOCH_W  epochs completed in the current or last run.
- sampleReq  out  1  request for the next sample.
- sampleAck  in  1  sample data is valid on the datapath inputs this cycle.
- yEqualt, flagEOF  in  1 each  datapath status.
- reset, nReset, ldRegN, ldRegx1, ldRegx2, ldRegT, ldRegW1, ldRegW2, ldRegB, ldRegFlag, flagReset, counterEn, counterReset  out  1 each  datapath controls; all active-high, Moore-decoded except the ld strobes noted below.
- timeoutErr  out  1  present only with NEURON_CTRL_TIMEOUT_EN.

Behaviour:
- rst=1 at any time, including mid-run: next state IDLE. epochCount=0, converged=0, done=0, busy=0, sampleReq=0, and all datapath controls 0. Datapath contents are not touched by the controller on rst.
- IDLE: start=1 -> CLR. start is ignored in every other state.
- CLR (1 cycle): reset=1, nReset=1 (clears x, t, w, b and n). epochCount<=0, converged<=0 -> LOADN.
- LOADN (1 cycle): ldRegN=1; the host holds nInput stable from start to this cycle -> EPOCH.
- EPOCH (1 cycle): counterReset=1, flagReset=1, internal errSeen<=0 -> CHECK.
- CHECK (1 cycle): evaluates flagEOF (counter==n), now reflecting the latest counter update.
  - flagEOF=0 -> FETCH.
  - flagEOF=1 and errSeen=0 -> DONE with converged<=1.
  - flagEOF=1, errSeen=1, epochCount==MAX_EPOCHS-1 -> epochCount++, then DONE with converged<=0.
  - Otherwise -> epochCount++, then EPOCH.
- n=0: CHECK sees flagEOF on the first pass -> converged=1, epochCount=0, no sampleReq is ever issued.
- FETCH: sampleReq=1 while waiting. On sampleAck=1, the same cycle asserts ldRegx1, ldRegx2 and ldRegT combinationally (Mealy) -> EVAL. sampleReq stays high during the ack cycle.
- EVAL (1 cycle): yEqualt is valid from the registered x/t and current w/b.
  - ldRegFlag=1 always.
  - yEqualt=0: ldRegW1, ldRegW2 and ldRegB =1, errSeen<=1.
  - -> NEXT.
- NEXT (1 cycle): counterEn=1 -> CHECK.
- DONE (1 cycle): done=1, busy=1 -> IDLE. busy falls the cycle after the done pulse.
- Throughput: with sampleAck in the same cycle as request, 4 cycles per sample (FETCH, EVAL, NEXT, CHECK); each extra ack-wait cycle adds 1.
- Invariant: at most one of the reset / ld / counter groups is active in any state, except the Mealy ld strobes in FETCH.

Optional Feature:
- Macro NEURON_CTRL_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to FETCH and increments every FETCH cycle without sampleAck.
  - Reaching ACK_TIMEOUT -> DONE with converged=0 and timeoutErr=1.
  - timeoutErr is cleared in CLR and by rst.
- Undefined: FETCH waits indefinitely; the timeoutErr port and the counter do not exist.

Decomposition:
- Package neuron_ctrl_pkg holds:
  - state enum (IDLE, CLR, LOADN, EPOCH, CHECK, FETCH, EVAL, NEXT, DONE), binary encoded;
  - default MAX_EPOCHS and EPOCH_W constants.
- One sub-module, neuron_ack_watchdog (load/count/expire), instantiated only under NEURON_CTRL_TIMEOUT_EN.
- Everything else stays in the FSM module.

Test Plan:
- Reset mid-FETCH (sampleReq=1): assert rst for 1 cycle -> next cycle busy=0, sampleReq=0, epochCount=0, all controls 0; a later start runs normally.
- n=0: start -> CLR, LOADN, EPOCH, CHECK, DONE; done pulses at cycle 5 after start, converged=1, epochCount=0, sampleReq never asserted.
- n=2, yEqualt forced 1, immediate ack: exactly 2 ldRegx1 pulses and 0 ldRegW1 pulses; done with converged=1, epochCount=0; 4 cycles per sample.
- n=2, yEqualt=0 in epoch 0 then 1: ldRegW1/W2/B pulse twice in epoch 0, epoch 1 is clean -> converged=1, epochCount=1.
- MAX_EPOCHS=3, yEqualt held 0: done after 3 epochs with converged=0, epochCount=3; start asserted while busy has no effect.
- NEURON_CTRL_TIMEOUT_EN, ACK_TIMEOUT=4, sampleAck never asserted: done 4 cycles after FETCH entry, timeoutErr=1, converged=0; the next start clears timeoutErr in CLR.
